// File: rtl/twowire_dtm_serial_if.sv
// Core-side serial interface between the two-wire line front-end and the DTM core.
// The front-end is the master and drives command/payload strobes; the core is the slave.
interface twowire_dtm_serial_if #(
    parameter int W_CMD = 4
);
    logic [3:0]       mdropaddr;
    logic             connected;
    logic [W_CMD-1:0] cmd;
    logic             cmd_vld;
    logic             cmd_payload_end;
    logic             disconnect_now;
    logic             serial_parity_err;
    logic             serial_wdata;
    logic             serial_wdata_vld;
    logic             serial_rdata;
    logic             serial_rdata_rdy;

    modport master (
        input  mdropaddr, cmd_payload_end, disconnect_now, serial_rdata,
        output connected, cmd, cmd_vld, serial_parity_err,
               serial_wdata, serial_wdata_vld, serial_rdata_rdy
    );

    modport slave (
        output mdropaddr, cmd_payload_end, disconnect_now, serial_rdata,
        input  connected, cmd, cmd_vld, serial_parity_err,
               serial_wdata, serial_wdata_vld, serial_rdata_rdy
    );
endinterface

// File: rtl/twowire_dtm_serial.sv
// Two-wire debug line front-end: connect/address detection, command framing with
// even parity, and bit-serial write/read payload streaming into the DTM core.
module twowire_dtm_serial #(
    parameter int                     W_CMD          = 4,
    parameter logic [7:0]             CONNECT_SEQ    = 8'ha7,
    parameter logic [(1<<W_CMD)-1:0]  WRITE_CMD_MASK = 16'h0228
) (
    input  logic                  dck,
    input  logic                  drst_n,
    input  logic                  di,
    output logic                  dout,
    output logic                  doe,
    twowire_dtm_serial_if.master  core
);
    localparam int CW = (W_CMD > 4) ? $clog2(W_CMD) : 2;

    typedef enum logic [3:0] {
        DISC, CADDR, IDLE, CMD, CPAR, ISSUE, WDATA, WPAR, RDATA, RPAR, RTURN
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       sreg;
    logic [7:0]       sreg_nxt;
    logic [CW-1:0]    cnt;
    logic [W_CMD-1:0] cmd_q;
    logic             par_acc;
    logic             perr_q;

    assign sreg_nxt = {sreg[6:0], di};

    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) state <= DISC;
        else         state <= state_nxt;
    end

    // Payload length belongs to the core: only cmd_payload_end ends a data phase.
    always_comb begin
        state_nxt = state;
        case (state)
            DISC:  if (sreg_nxt == CONNECT_SEQ) state_nxt = CADDR;
            CADDR: if (cnt == '0) state_nxt = ({sreg[2:0], di} == core.mdropaddr) ? IDLE : DISC;
            IDLE:  if (!di) state_nxt = CMD;
            CMD:   if (cnt == '0) state_nxt = CPAR;
            CPAR:  state_nxt = (di != ^cmd_q) ? IDLE : ISSUE;
            ISSUE: begin
                if (core.disconnect_now)       state_nxt = DISC;
                else if (WRITE_CMD_MASK[cmd_q]) state_nxt = WDATA;
                else                            state_nxt = RDATA;
            end
            WDATA: if (core.cmd_payload_end) state_nxt = WPAR;
            WPAR:  state_nxt = IDLE;
            RDATA: if (core.cmd_payload_end) state_nxt = RPAR;
            RPAR:  state_nxt = RTURN;
            RTURN: state_nxt = IDLE;
            default: state_nxt = DISC;
        endcase
    end

    always_comb begin
        core.connected        = 1'b1;
        core.cmd_vld          = 1'b0;
        core.serial_wdata_vld = 1'b0;
        core.serial_rdata_rdy = 1'b0;
        doe                   = 1'b0;
        dout                  = 1'b1;
        case (state)
            DISC, CADDR: core.connected = 1'b0;
            ISSUE:       core.cmd_vld = 1'b1;
            WDATA:       core.serial_wdata_vld = 1'b1;
            RDATA: begin
                doe                   = 1'b1;
                dout                  = core.serial_rdata;
                core.serial_rdata_rdy = 1'b1;
            end
            RPAR: begin
                doe  = 1'b1;
                dout = par_acc;
            end
            default: ;
        endcase
    end

    assign core.serial_wdata      = di;
    assign core.cmd               = cmd_q;
    assign core.serial_parity_err = perr_q;

    // Shift register, bit counter, command and payload parity; sreg is cleared
    // whenever the link falls back so a fresh connect pattern is always required.
    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            sreg    <= '0;
            cnt     <= '0;
            cmd_q   <= '0;
            par_acc <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            perr_q <= ((state == CPAR) && (di != ^cmd_q)) ||
                      ((state == WPAR) && (di != par_acc));
            case (state)
                DISC: begin
                    sreg <= sreg_nxt;
                    cnt  <= CW'(3);
                end
                CADDR: begin
                    sreg <= (cnt == '0) ? '0 : sreg_nxt;
                    cnt  <= cnt - CW'(1);
                end
                IDLE: cnt <= CW'(W_CMD - 1);
                CMD: begin
                    cmd_q <= {cmd_q[W_CMD-2:0], di};
                    cnt   <= cnt - CW'(1);
                end
                ISSUE: begin
                    par_acc <= 1'b0;
                    if (core.disconnect_now) sreg <= '0;
                end
                WDATA:   par_acc <= par_acc ^ di;
                RDATA:   par_acc <= par_acc ^ core.serial_rdata;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_twowire_dtm_serial.sv
// Randomized bench for twowire_dtm_serial: a host/core transaction model predicts
// line and core-side behaviour frame by frame from the protocol rules.
module tb_twowire_dtm_serial;
    logic dck = 1'b0;
    logic drst_n = 1'b0;
    logic di = 1'b1;
    logic dout, doe;

    twowire_dtm_serial_if #(.W_CMD(4)) core_if ();

    twowire_dtm_serial #(.W_CMD(4)) dut (
        .dck    (dck),
        .drst_n (drst_n),
        .di     (di),
        .dout   (dout),
        .doe    (doe),
        .core   (core_if.master)
    );

    always #5 dck = ~dck;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_conn = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change just after a rising edge; outputs are then observed for that cycle.
    task automatic applyStimulus(input logic d, input logic pe, input logic dn, input logic rd);
        @(posedge dck);
        #1;
        di                      = d;
        core_if.cmd_payload_end = pe;
        core_if.disconnect_now  = dn;
        core_if.serial_rdata    = rd;
        #1;
    endtask

    function automatic bit isWriteCmd(input logic [3:0] c);
        return (c == 4'd3) || (c == 4'd5) || (c == 4'd9);
    endfunction

    task automatic idleCycle();
        applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        checkOutput("idle_conn", core_if.connected, exp_conn);
        checkOutput("idle_vld", core_if.cmd_vld, 0);
        checkOutput("idle_doe", doe, 0);
        checkOutput("idle_dout", dout, 1);
        checkOutput("idle_perr", core_if.serial_parity_err, 0);
    endtask

    task automatic doConnect(input logic [3:0] line_addr, input logic [3:0] core_addr);
        logic [15:0] seq;
        core_if.mdropaddr = core_addr;
        seq = {4'hf, 8'ha7, line_addr};
        for (int i = 15; i >= 0; i--) begin
            applyStimulus(seq[i], 1'b0, 1'b0, 1'b0);
            checkOutput("conn_pre", core_if.connected, 0);
        end
        exp_conn = (line_addr == core_addr);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("conn_post", core_if.connected, exp_conn);
    endtask

    task automatic doFrame(input logic [3:0] c, input bit bad_cpar, input bit disc,
                           input int len, input logic [63:0] data, input bit bad_dpar,
                           input int rst_at);
        logic par;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("start_conn", core_if.connected, 1);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(c[i], 1'b0, 1'b0, 1'b0);
            checkOutput("cmd_novld", core_if.cmd_vld, 0);
        end
        applyStimulus((^c) ^ bad_cpar, 1'b0, 1'b0, 1'b0);
        checkOutput("cpar_novld", core_if.cmd_vld, 0);
        if (bad_cpar) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("cpar_err", core_if.serial_parity_err, 1);
            checkOutput("cpar_err_novld", core_if.cmd_vld, 0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("cpar_err_single", core_if.serial_parity_err, 0);
            checkOutput("cpar_err_novld2", core_if.cmd_vld, 0);
            return;
        end
        applyStimulus(1'b1, 1'b0, disc, 1'b0);
        checkOutput("issue_vld", core_if.cmd_vld, 1);
        checkOutput("issue_cmd", core_if.cmd, c);
        checkOutput("issue_doe", doe, 0);
        checkOutput("issue_wvld", core_if.serial_wdata_vld, 0);
        if (disc) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("disc_conn", core_if.connected, 0);
            checkOutput("disc_vld", core_if.cmd_vld, 0);
            exp_conn = 1'b0;
            return;
        end
        par = 1'b0;
        if (isWriteCmd(c)) begin
            for (int i = 0; i < len; i++) begin
                par ^= data[i];
                applyStimulus(data[i], 1'(i == len - 1), 1'b0, 1'b0);
                checkOutput("wr_vld", core_if.serial_wdata_vld, 1);
                checkOutput("wr_bit", core_if.serial_wdata, data[i]);
                checkOutput("wr_doe", doe, 0);
                checkOutput("wr_cmd_hold", core_if.cmd, c);
            end
            applyStimulus(par ^ bad_dpar, 1'b0, 1'b0, 1'b0);
            checkOutput("wpar_wvld", core_if.serial_wdata_vld, 0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("wpar_err", core_if.serial_parity_err, bad_dpar);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("wpar_err_single", core_if.serial_parity_err, 0);
        end else begin
            for (int i = 0; i < len; i++) begin
                par ^= data[i];
                applyStimulus(1'b1, 1'(i == len - 1), 1'b0, data[i]);
                if (i == rst_at) begin
                    drst_n = 1'b0;
                    #1;
                    checkOutput("rst_doe", doe, 0);
                    checkOutput("rst_dout", dout, 1);
                    checkOutput("rst_rdy", core_if.serial_rdata_rdy, 0);
                    checkOutput("rst_vld", core_if.cmd_vld, 0);
                    checkOutput("rst_conn", core_if.connected, 0);
                    checkOutput("rst_wvld", core_if.serial_wdata_vld, 0);
                    checkOutput("rst_perr", core_if.serial_parity_err, 0);
                    @(posedge dck);
                    #2;
                    drst_n   = 1'b1;
                    exp_conn = 1'b0;
                    return;
                end
                checkOutput("rd_doe", doe, 1);
                checkOutput("rd_dout", dout, data[i]);
                checkOutput("rd_rdy", core_if.serial_rdata_rdy, 1);
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom));
            checkOutput("rpar_doe", doe, 1);
            checkOutput("rpar_dout", dout, par);
            checkOutput("rpar_rdy", core_if.serial_rdata_rdy, 0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom));
            checkOutput("rturn_doe", doe, 0);
            checkOutput("rturn_dout", dout, 1);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom));
            checkOutput("ridle_doe", doe, 0);
            checkOutput("ridle_conn", core_if.connected, 1);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] a;
        logic [5:0] junk;
        core_if.mdropaddr       = 4'h0;
        core_if.cmd_payload_end = 1'b0;
        core_if.disconnect_now  = 1'b0;
        core_if.serial_rdata    = 1'b0;
        #2;
        checkOutput("reset_conn", core_if.connected, 0);
        checkOutput("reset_cmd", core_if.cmd, 0);
        checkOutput("reset_vld", core_if.cmd_vld, 0);
        checkOutput("reset_perr", core_if.serial_parity_err, 0);
        checkOutput("reset_wvld", core_if.serial_wdata_vld, 0);
        checkOutput("reset_rdy", core_if.serial_rdata_rdy, 0);
        checkOutput("reset_dout", dout, 1);
        checkOutput("reset_doe", doe, 0);
        #10;
        drst_n = 1'b1;

        doConnect(4'h5, 4'h3);
        idleCycle();
        doConnect(4'h3, 4'h3);
        idleCycle();

        doFrame(4'h1, 1'b0, 1'b0, 32, {$urandom, $urandom}, 1'b0, -1);
        doFrame(4'h3, 1'b0, 1'b0, 32, {$urandom, $urandom}, 1'b0, -1);
        doFrame(4'h3, 1'b0, 1'b0, 32, {$urandom, $urandom}, 1'b1, -1);
        doFrame(4'h5, 1'b1, 1'b0, 32, {$urandom, $urandom}, 1'b0, -1);
        doFrame(4'h1, 1'b0, 1'b0, 8,  {$urandom, $urandom}, 1'b0, -1);

        doFrame(4'h0, 1'b0, 1'b1, 0, 64'd0, 1'b0, -1);
        junk = 6'b000011;
        for (int i = 5; i >= 0; i--) begin
            applyStimulus(junk[i], 1'b0, 1'b0, 1'b0);
            checkOutput("post_disc_vld", core_if.cmd_vld, 0);
            checkOutput("post_disc_conn", core_if.connected, 0);
        end
        doConnect(4'h3, 4'h3);

        for (int n = 0; n < 30; n++) begin
            doFrame(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 7) == 0), $urandom_range(1, 40),
                    {$urandom, $urandom}, ($urandom_range(0, 3) == 0), -1);
            if (!exp_conn) begin
                a = 4'($urandom_range(0, 15));
                doConnect(a, a);
            end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) idleCycle();
        end

        doFrame(4'h1, 1'b0, 1'b0, 32, {$urandom, $urandom}, 1'b0, 10);
        for (int k = 0; k < 3; k++) idleCycle();
        doConnect(4'h3, 4'h3);
        doFrame(4'h1, 1'b0, 1'b0, 4, {$urandom, $urandom}, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
